// File: rtl/regbank_wr_queue.sv
// Write queue in front of the 32x32 register bank: FIFO of pending writes,
// in-order drain into the single bank write port, and youngest-wins forwarding.
`timescale 1ns/1ps
module regbank_wr_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_data,
  input  logic          drain_en,
  output logic          rb_write,
  output logic [AW-1:0] rb_dr,
  output logic [DW-1:0] rb_wrData,
  input  logic [AW-1:0] lk_addr1,
  input  logic [AW-1:0] lk_addr2,
  output logic          lk_hit1,
  output logic          lk_hit2,
  output logic [DW-1:0] lk_data1,
  output logic [DW-1:0] lk_data2,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    lk_idx;
  logic             push, pop;

  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign in_ready  = reset & ~full;
  assign push      = in_valid & in_ready;
  assign pop       = drain_en & ~empty;
  assign rb_write  = pop;
  assign rb_dr     = addr_q[rd_ptr_q];
  assign rb_wrData = data_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    valid_d  = valid_q;
    count_d  = count_q;
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
    if (push) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
    end
  end

  // Payload is deliberately not reset; valid bits alone qualify it.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= in_addr;
      data_q[wr_ptr_q] <= in_data;
    end
  end

  // Walk oldest to youngest from rd_ptr so the last match wins.
  always_comb begin
    lk_hit1  = 1'b0;
    lk_hit2  = 1'b0;
    lk_data1 = '0;
    lk_data2 = '0;
    lk_idx   = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      lk_idx = rd_ptr_q + PW'(i);
      if (valid_q[lk_idx] && (addr_q[lk_idx] == lk_addr1)) begin
        lk_hit1  = 1'b1;
        lk_data1 = data_q[lk_idx];
      end
      if (valid_q[lk_idx] && (addr_q[lk_idx] == lk_addr2)) begin
        lk_hit2  = 1'b1;
        lk_data2 = data_q[lk_idx];
      end
    end
  end

endmodule

// File: tb/tb_regbank_wr_queue.sv
// Self-checking bench for regbank_wr_queue: queue-based reference model,
// table-driven forwarding vectors, directed corner cases and random traffic.
`timescale 1ns/1ps
module tb_regbank_wr_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_addr = '0;
  logic [DW-1:0] in_data = '0;
  logic          drain_en = 1'b0;
  logic          rb_write;
  logic [AW-1:0] rb_dr;
  logic [DW-1:0] rb_wrData;
  logic [AW-1:0] lk_addr1 = '0;
  logic [AW-1:0] lk_addr2 = '0;
  logic          lk_hit1, lk_hit2;
  logic [DW-1:0] lk_data1, lk_data2;
  logic [CW-1:0] count;
  logic          empty, full;

  regbank_wr_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .drain_en(drain_en), .rb_write(rb_write), .rb_dr(rb_dr), .rb_wrData(rb_wrData),
    .lk_addr1(lk_addr1), .lk_addr2(lk_addr2), .lk_hit1(lk_hit1), .lk_hit2(lk_hit2),
    .lk_data1(lk_data1), .lk_data2(lk_data2), .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    logic          v;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          dr;
    logic [AW-1:0] l1;
    logic [AW-1:0] l2;
    int            cnt;
    logic          h1;
    logic [DW-1:0] d1;
    logic          h2;
    logic [DW-1:0] d2;
    logic          w;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
  } vec_t;

  wr_t           mq[$];
  wr_t           wlog[$];
  int            wcyc[$];
  logic [DW-1:0] mbank[32];
  logic [DW-1:0] dbank[32];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_lookup(input logic [AW-1:0] a, output logic hit, output logic [DW-1:0] d);
    hit = 1'b0;
    d   = '0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].addr == a) begin
        hit = 1'b1;
        d   = mq[i].data;
        break;
      end
    end
  endtask

  task automatic check_model();
    logic          eh;
    logic [DW-1:0] ed;
    int            n;
    n = mq.size();
    chk("m_in_ready", in_ready, reset && (n < DEPTH));
    chk("m_rb_write", rb_write, reset && drain_en && (n > 0));
    if (reset && drain_en && (n > 0)) begin
      chk("m_rb_dr", rb_dr, mq[0].addr);
      chk("m_rb_wrData", rb_wrData, mq[0].data);
    end
    chk("m_count", count, n);
    chk("m_empty", empty, n == 0);
    chk("m_full", full, n == DEPTH);
    model_lookup(lk_addr1, eh, ed);
    chk("m_lk_hit1", lk_hit1, eh);
    chk("m_lk_data1", lk_data1, ed);
    model_lookup(lk_addr2, eh, ed);
    chk("m_lk_hit2", lk_hit2, eh);
    chk("m_lk_data2", lk_data2, ed);
  endtask

  // One clock: check against model, cross the edge, then update model and bank.
  task automatic step();
    logic          w, mpush, mpop;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    wr_t           e;
    #1;
    check_model();
    w     = rb_write;
    a     = rb_dr;
    d     = rb_wrData;
    mpush = reset && in_valid && (mq.size() < DEPTH);
    mpop  = reset && drain_en && (mq.size() > 0);
    e.addr = in_addr;
    e.data = in_data;
    @(posedge clk);
    cyc++;
    if (reset && w) begin
      dbank[a] = d;
      wlog.push_back('{addr: a, data: d});
      wcyc.push_back(cyc);
    end
    if (mpop) begin
      mbank[mq[0].addr] = mq[0].data;
      void'(mq.pop_front());
    end
    if (mpush) mq.push_back(e);
    if (!reset) mq.delete();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    int   base, acc_t, t;
    logic pending;

    for (int r = 0; r < 32; r++) begin
      mbank[r] = '0;
      dbank[r] = '0;
    end

    // Reset then idle
    @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_rb_write", rb_write, 1'b0);
    for (int i = 0; i < 3; i++) step();
    reset = 1'b1;
    lk_addr1 = 5'd5;
    lk_addr2 = 5'd0;
    #1;
    chk("idle_in_ready", in_ready, 1'b1);
    chk("idle_empty", empty, 1'b1);
    chk("idle_count", count, 0);
    chk("idle_rb_write", rb_write, 1'b0);
    chk("idle_lk_hit1", lk_hit1, 1'b0);
    chk("idle_lk_hit2", lk_hit2, 1'b0);

    // Single write, no write-through on the push edge
    drain_en = 1'b1;
    in_valid = 1'b1;
    in_addr  = 5'd5;
    in_data  = 32'hDEADBEEF;
    step();
    in_valid = 1'b0;
    chk("single_rb_write", rb_write, 1'b1);
    chk("single_rb_dr", rb_dr, 5'd5);
    chk("single_rb_wrData", rb_wrData, 32'hDEADBEEF);
    step();
    chk("single_empty", empty, 1'b1);
    chk("single_bank5", dbank[5], 32'hDEADBEEF);

    // Fill, block, then drain with a held request
    drain_en = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1;
      in_addr  = AW'(k);
      in_data  = DW'(k * 10);
      step();
    end
    in_addr = 5'd5;
    in_data = 32'd50;
    chk("fill_full", full, 1'b1);
    chk("fill_count", count, 4);
    chk("fill_in_ready", in_ready, 1'b0);
    step();
    step();
    chk("fill_held_count", count, 4);
    drain_en = 1'b1;
    base  = wlog.size();
    acc_t = -1;
    t     = 0;
    while (t < 20 && (in_valid || mq.size() > 0)) begin
      if (in_valid && in_ready) acc_t = t;
      step();
      if (acc_t == t) in_valid = 1'b0;
      t++;
    end
    chk("fill_held_accept_cycle", acc_t, 1);
    chk("fill_nwrites", wlog.size() - base, 5);
    if (wlog.size() - base == 5) begin
      for (int k = 0; k < 5; k++) begin
        chk("fill_order_addr", wlog[base+k].addr, AW'(k + 1));
        chk("fill_order_data", wlog[base+k].data, DW'((k + 1) * 10));
      end
      chk("fill_consecutive", wcyc[base+3] - wcyc[base], 3);
    end

    // Forwarding, youngest wins (expected values are pre-edge)
    tbl[0] = '{1'b1, 5'd7, 32'h11, 1'b0, 5'd7, 5'd9, 0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 5'd0, 32'h0};
    tbl[1] = '{1'b1, 5'd7, 32'h22, 1'b0, 5'd7, 5'd9, 1, 1'b1, 32'h11, 1'b0, 32'h0,  1'b0, 5'd0, 32'h0};
    tbl[2] = '{1'b1, 5'd3, 32'h33, 1'b0, 5'd7, 5'd9, 2, 1'b1, 32'h22, 1'b0, 32'h0,  1'b0, 5'd0, 32'h0};
    tbl[3] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd7, 5'd9, 3, 1'b1, 32'h22, 1'b0, 32'h0,  1'b0, 5'd0, 32'h0};
    tbl[4] = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd7, 5'd9, 3, 1'b1, 32'h22, 1'b0, 32'h0,  1'b1, 5'd7, 32'h11};
    tbl[5] = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd7, 5'd3, 2, 1'b1, 32'h22, 1'b1, 32'h33, 1'b1, 5'd7, 32'h22};
    tbl[6] = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd7, 5'd9, 1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 5'd3, 32'h33};
    tbl[7] = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd7, 5'd9, 0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 5'd0, 32'h0};
    for (int i = 0; i < 8; i++) begin
      in_valid = tbl[i].v;
      in_addr  = tbl[i].a;
      in_data  = tbl[i].d;
      drain_en = tbl[i].dr;
      lk_addr1 = tbl[i].l1;
      lk_addr2 = tbl[i].l2;
      #1;
      chk("fwd_count", count, tbl[i].cnt);
      chk("fwd_hit1", lk_hit1, tbl[i].h1);
      chk("fwd_data1", lk_data1, tbl[i].d1);
      chk("fwd_hit2", lk_hit2, tbl[i].h2);
      chk("fwd_data2", lk_data2, tbl[i].d2);
      chk("fwd_rb_write", rb_write, tbl[i].w);
      if (tbl[i].w) begin
        chk("fwd_rb_dr", rb_dr, tbl[i].wa);
        chk("fwd_rb_wrData", rb_wrData, tbl[i].wd);
      end
      step();
    end
    chk("fwd_bank7", dbank[7], 32'h22);
    chk("fwd_hit1_after", lk_hit1, 1'b0);

    // Steady push+pop at count 2 with pointer wrap
    drain_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_addr  = AW'(10 + k);
      in_data  = DW'(100 + k);
      step();
    end
    base = wlog.size();
    drain_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_addr = AW'(12 + (k % 4));
      in_data = DW'(200 + k);
      #1;
      chk("wrap_count", count, 2);
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 10 && mq.size() > 0; k++) step();
    chk("wrap_nwrites", wlog.size() - base, 12);
    if (wlog.size() - base == 12) begin
      for (int k = 0; k < 12; k++)
        chk("wrap_order", wlog[base+k].data, (k < 2) ? DW'(100 + k) : DW'(198 + k));
    end

    // Asynchronous reset mid-operation
    drain_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_addr  = AW'(20 + k);
      in_data  = DW'(32'hA0 + k);
      step();
    end
    in_valid = 1'b0;
    drain_en = 1'b1;
    lk_addr1 = 5'd20;
    #1;
    chk("mid_rb_write_before", rb_write, 1'b1);
    #1;
    reset = 1'b0;
    mq.delete();
    #1;
    chk("mid_rb_write", rb_write, 1'b0);
    chk("mid_count", count, 0);
    chk("mid_empty", empty, 1'b1);
    chk("mid_in_ready", in_ready, 1'b0);
    chk("mid_lk_hit1", lk_hit1, 1'b0);
    base = wlog.size();
    step();
    step();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) step();
    chk("mid_no_stale", wlog.size() - base, 0);
    chk("mid_bank20", dbank[20], 32'h0);

    // Randomized traffic against the model
    pending = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!pending) begin
        in_valid = 1'($urandom_range(0, 1));
        in_addr  = AW'($urandom_range(0, 7));
        in_data  = $urandom;
      end
      drain_en = 1'($urandom_range(0, 1));
      lk_addr1 = AW'($urandom_range(0, 7));
      lk_addr2 = AW'($urandom_range(0, 7));
      pending  = in_valid && !in_ready;
      step();
    end
    in_valid = 1'b0;
    drain_en = 1'b1;
    for (int k = 0; k < 20 && mq.size() > 0; k++) step();
    chk("rand_drained", mq.size(), 0);
    for (int r = 0; r < 32; r++) chk("rand_bank", dbank[r], mbank[r]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
